// File: rtl/riscv_pkg.sv
// Shared types and helpers for the RISC-V core memory path.
package riscv_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        MEM_B = 2'd0,
        MEM_H = 2'd1,
        MEM_W = 2'd2
    } mem_size_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } mem_state_t;

    // The unused size encoding 3 is treated as a full word.
    function automatic mem_size_t to_size(input logic [1:0] raw);
        case (raw)
            2'd0:    return MEM_B;
            2'd1:    return MEM_H;
            default: return MEM_W;
        endcase
    endfunction

    // Byte enables for a store; H looks only at addr[1], W at neither bit.
    function automatic logic [3:0] store_strb(input mem_size_t size, input logic [1:0] addr_lo);
        case (size)
            MEM_B:   return 4'b0001 << addr_lo;
            MEM_H:   return addr_lo[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/load_align.sv
// Load data lane select and sign/zero extension.
module load_align #(
    parameter int XLEN = riscv_pkg::XLEN
) (
    input  logic [XLEN-1:0]       rdata,
    input  logic [1:0]            addr_lo,
    input  riscv_pkg::mem_size_t  size,
    input  logic                  is_unsigned,
    output logic [XLEN-1:0]       data
);
    import riscv_pkg::*;

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Pick the addressed byte/half and extend it to XLEN.
    always_comb begin
        byte_sel = rdata[{addr_lo, 3'b000} +: 8];
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        case (size)
            MEM_B:   data = {{(XLEN-8){~is_unsigned & byte_sel[7]}}, byte_sel};
            MEM_H:   data = {{(XLEN-16){~is_unsigned & half_sel[15]}}, half_sel};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory stage: passes ALU results through in one cycle, runs loads and
// stores over a valid/ready request + valid response data memory port.
// Build option: MEM_MISALIGN_TRAP_EN turns misaligned H/W accesses into a
// one-cycle trap instead of silently aligning them.
//
// state | meaning
// IDLE  | ready for a new instruction; ALU ops complete from here
// REQ   | memory request presented, waiting for dmem_req_ready
// RESP  | request accepted, waiting for dmem_resp_valid
module mem_stage #(
    parameter int XLEN   = riscv_pkg::XLEN,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [4:0]        rd_addr_in,
    input  logic [XLEN-1:0]   rd_in,
    input  logic              writeback_en_in,
    input  logic              writeback_from_mem_in,
    input  logic              mem_write_in,
    input  logic [1:0]        mem_size_in,
    input  logic              mem_unsigned_in,
    input  logic [XLEN-1:0]   store_data_in,
    output logic              stall,
    output logic              dmem_req_valid,
    input  logic              dmem_req_ready,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic              dmem_we,
    output logic [3:0]        dmem_wstrb,
    output logic [XLEN-1:0]   dmem_wdata,
    input  logic              dmem_resp_valid,
    input  logic [XLEN-1:0]   dmem_rdata,
    output logic              wb_valid,
    output logic [4:0]        wb_rd_addr,
    output logic [XLEN-1:0]   wb_data,
    output logic              wb_en,
    output logic              trap
);
    import riscv_pkg::*;

    mem_state_t state_q, state_d;
    mem_size_t  size_in;
    logic       is_mem;
    logic       misalign;
    logic       accept;

    logic [4:0]        h_rd_addr;
    logic [ADDR_W-1:0] h_addr;
    logic              h_we;
    logic [3:0]        h_wstrb;
    logic [XLEN-1:0]   h_wdata;
    mem_size_t         h_size;
    logic              h_unsigned;
    logic              h_wb_en;
    logic [XLEN-1:0]   store_lanes;
    logic [XLEN-1:0]   load_data;

    assign size_in = to_size(mem_size_in);
    assign is_mem  = writeback_from_mem_in | mem_write_in;

`ifdef MEM_MISALIGN_TRAP_EN
    assign misalign = (size_in == MEM_H && rd_in[0]) ||
                      (size_in == MEM_W && rd_in[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    assign accept = (state_q == IDLE) && in_valid && is_mem && !misalign;

    // Next state and combinational handshake outputs.
    always_comb begin
        state_d = state_q;
        stall   = 1'b1;
        case (state_q)
            IDLE: begin
                stall = accept;
                if (accept)
                    state_d = REQ;
            end
            REQ: begin
                if (dmem_req_ready)
                    state_d = RESP;
            end
            RESP: begin
                if (dmem_resp_valid)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Replicate the store byte/half across all lanes.
    always_comb begin
        case (size_in)
            MEM_B:   store_lanes = {(XLEN/8){store_data_in[7:0]}};
            MEM_H:   store_lanes = {(XLEN/16){store_data_in[15:0]}};
            default: store_lanes = store_data_in;
        endcase
    end

    // Capture the memory op so upstream changes cannot disturb the request.
    always_ff @(posedge clk) begin
        if (rst) begin
            h_rd_addr  <= '0;
            h_addr     <= '0;
            h_we       <= 1'b0;
            h_wstrb    <= '0;
            h_wdata    <= '0;
            h_size     <= MEM_B;
            h_unsigned <= 1'b0;
            h_wb_en    <= 1'b0;
        end else if (accept) begin
            h_rd_addr  <= rd_addr_in;
            h_addr     <= rd_in[ADDR_W-1:0];
            h_we       <= mem_write_in;
            h_wstrb    <= mem_write_in ? store_strb(size_in, rd_in[1:0]) : 4'b0000;
            h_wdata    <= mem_write_in ? store_lanes : '0;
            h_size     <= size_in;
            h_unsigned <= mem_unsigned_in;
            h_wb_en    <= writeback_en_in && (rd_addr_in != 5'd0);
        end
    end

    assign dmem_req_valid = (state_q == REQ);
    assign dmem_addr      = {h_addr[ADDR_W-1:2], 2'b00};
    assign dmem_we        = h_we;
    assign dmem_wstrb     = h_wstrb;
    assign dmem_wdata     = h_wdata;

    load_align #(.XLEN(XLEN)) u_load_align (
        .rdata       (dmem_rdata),
        .addr_lo     (h_addr[1:0]),
        .size        (h_size),
        .is_unsigned (h_unsigned),
        .data        (load_data)
    );

    // M/WB register: one-cycle pulse of wb_valid per completed instruction.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid   <= 1'b0;
            wb_en      <= 1'b0;
            wb_rd_addr <= '0;
            wb_data    <= '0;
        end else begin
            wb_valid <= 1'b0;
            wb_en    <= 1'b0;
            if (state_q == IDLE && in_valid && (!is_mem || misalign)) begin
                wb_valid   <= 1'b1;
                wb_rd_addr <= rd_addr_in;
                wb_data    <= rd_in;
                wb_en      <= !is_mem && writeback_en_in && (rd_addr_in != 5'd0);
            end else if (state_q == RESP && dmem_resp_valid) begin
                wb_valid   <= 1'b1;
                wb_rd_addr <= h_rd_addr;
                wb_data    <= h_we ? '0 : load_data;
                wb_en      <= !h_we && h_wb_en;
            end
        end
    end

`ifdef MEM_MISALIGN_TRAP_EN
    // Trap pulses alongside the wb_valid of the faulting instruction.
    always_ff @(posedge clk) begin
        if (rst)
            trap <= 1'b0;
        else
            trap <= (state_q == IDLE) && in_valid && is_mem && misalign;
    end
`else
    assign trap = 1'b0;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage; inputs change and outputs are checked on
// the falling edge.
module tb_mem_stage;
    localparam int XLEN   = 32;
    localparam int ADDR_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic [4:0]        rd_addr_in;
    logic [XLEN-1:0]   rd_in;
    logic              writeback_en_in;
    logic              writeback_from_mem_in;
    logic              mem_write_in;
    logic [1:0]        mem_size_in;
    logic              mem_unsigned_in;
    logic [XLEN-1:0]   store_data_in;
    logic              stall;
    logic              dmem_req_valid;
    logic              dmem_req_ready;
    logic [ADDR_W-1:0] dmem_addr;
    logic              dmem_we;
    logic [3:0]        dmem_wstrb;
    logic [XLEN-1:0]   dmem_wdata;
    logic              dmem_resp_valid;
    logic [XLEN-1:0]   dmem_rdata;
    logic              wb_valid;
    logic [4:0]        wb_rd_addr;
    logic [XLEN-1:0]   wb_data;
    logic              wb_en;
    logic              trap;

    int n_vec = 0;
    int n_err = 0;

    mem_stage #(.XLEN(XLEN), .ADDR_W(ADDR_W)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .in_valid              (in_valid),
        .rd_addr_in            (rd_addr_in),
        .rd_in                 (rd_in),
        .writeback_en_in       (writeback_en_in),
        .writeback_from_mem_in (writeback_from_mem_in),
        .mem_write_in          (mem_write_in),
        .mem_size_in           (mem_size_in),
        .mem_unsigned_in       (mem_unsigned_in),
        .store_data_in         (store_data_in),
        .stall                 (stall),
        .dmem_req_valid        (dmem_req_valid),
        .dmem_req_ready        (dmem_req_ready),
        .dmem_addr             (dmem_addr),
        .dmem_we               (dmem_we),
        .dmem_wstrb            (dmem_wstrb),
        .dmem_wdata            (dmem_wdata),
        .dmem_resp_valid       (dmem_resp_valid),
        .dmem_rdata            (dmem_rdata),
        .wb_valid              (wb_valid),
        .wb_rd_addr            (wb_rd_addr),
        .wb_data               (wb_data),
        .wb_en                 (wb_en),
        .trap                  (trap)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [4:0] rd, input logic [31:0] addr, input logic wben,
                         input logic load, input logic store, input logic [1:0] size,
                         input logic uns, input logic [31:0] sdata);
        in_valid              = 1'b1;
        rd_addr_in            = rd;
        rd_in                 = addr;
        writeback_en_in       = wben;
        writeback_from_mem_in = load;
        mem_write_in          = store;
        mem_size_in           = size;
        mem_unsigned_in       = uns;
        store_data_in         = sdata;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_wb_valid"}, 32'(wb_valid), 32'd0);
        chk({tag, "_wb_en"},    32'(wb_en), 32'd0);
        chk({tag, "_wb_rd"},    32'(wb_rd_addr), 32'd0);
        chk({tag, "_wb_data"},  wb_data, 32'd0);
        chk({tag, "_req"},      32'(dmem_req_valid), 32'd0);
        chk({tag, "_we"},       32'(dmem_we), 32'd0);
        chk({tag, "_wstrb"},    32'(dmem_wstrb), 32'd0);
        chk({tag, "_addr"},     dmem_addr, 32'd0);
        chk({tag, "_wdata"},    dmem_wdata, 32'd0);
        chk({tag, "_trap"},     32'(trap), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        issue(5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 32'd0);
        in_valid = 1'b0;
        dmem_req_ready = 1'b0;
        dmem_resp_valid = 1'b0;
        dmem_rdata = 32'd0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        // ALU pass-through
        @(negedge clk);
        issue(5'd5, 32'h1234, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 32'd0);
        #1 chk("alu_stall_issue", 32'(stall), 32'd0);
        @(negedge clk);
        chk("alu_wb_valid", 32'(wb_valid), 32'd1);
        chk("alu_wb_rd",    32'(wb_rd_addr), 32'd5);
        chk("alu_wb_data",  wb_data, 32'h1234);
        chk("alu_wb_en",    32'(wb_en), 32'd1);
        chk("alu_stall_wb", 32'(stall), 32'd0);
        in_valid = 1'b0;
        @(negedge clk);
        chk("alu_wb_pulse", 32'(wb_valid), 32'd0);

        // LB 0x103, immediate ready and response; early resp is ignored in IDLE
        dmem_req_ready = 1'b1;
        dmem_resp_valid = 1'b1;
        dmem_rdata = 32'h80FF_0000;
        issue(5'd7, 32'h103, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 32'd0);
        #1 chk("lb_stall_c0", 32'(stall), 32'd1);
        chk("lb_req_c0", 32'(dmem_req_valid), 32'd0);
        @(negedge clk);
        chk("lb_req_c1",   32'(dmem_req_valid), 32'd1);
        chk("lb_addr",     dmem_addr, 32'h100);
        chk("lb_we",       32'(dmem_we), 32'd0);
        chk("lb_stall_c1", 32'(stall), 32'd1);
        chk("lb_wbv_c1",   32'(wb_valid), 32'd0);
        @(negedge clk);
        chk("lb_req_c2",   32'(dmem_req_valid), 32'd0);
        chk("lb_stall_c2", 32'(stall), 32'd1);
        chk("lb_wbv_c2",   32'(wb_valid), 32'd0);
        in_valid = 1'b0;
        @(negedge clk);
        dmem_resp_valid = 1'b0;
        chk("lb_wb_valid", 32'(wb_valid), 32'd1);
        chk("lb_wb_data",  wb_data, 32'hFFFF_FF80);
        chk("lb_wb_rd",    32'(wb_rd_addr), 32'd7);
        chk("lb_wb_en",    32'(wb_en), 32'd1);
        chk("lb_stall_c3", 32'(stall), 32'd0);

        // SH 0x102 with ready held off for four cycles
        dmem_req_ready = 1'b0;
        issue(5'd3, 32'h102, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 32'h0000_ABCD);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("sh_req_wait",   32'(dmem_req_valid), 32'd1);
            chk("sh_addr_wait",  dmem_addr, 32'h100);
            chk("sh_we_wait",    32'(dmem_we), 32'd1);
            chk("sh_wstrb_wait", 32'(dmem_wstrb), 32'hC);
            chk("sh_wdata_wait", dmem_wdata, 32'hABCD_ABCD);
            chk("sh_stall_wait", 32'(stall), 32'd1);
            store_data_in = 32'h1111_2222;
            rd_in = 32'h0;
        end
        @(negedge clk);
        chk("sh_req_last", 32'(dmem_req_valid), 32'd1);
        dmem_req_ready = 1'b1;
        @(negedge clk);
        chk("sh_req_drop", 32'(dmem_req_valid), 32'd0);
        dmem_req_ready = 1'b0;
        dmem_resp_valid = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        dmem_resp_valid = 1'b0;
        chk("sh_wb_valid", 32'(wb_valid), 32'd1);
        chk("sh_wb_en",    32'(wb_en), 32'd0);

        // LW to x0
        dmem_req_ready = 1'b1;
        dmem_resp_valid = 1'b1;
        dmem_rdata = 32'h1234_5678;
        issue(5'd0, 32'h200, 1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 32'd0);
        @(negedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        chk("lw_x0_wb_valid", 32'(wb_valid), 32'd1);
        chk("lw_x0_wb_en",    32'(wb_en), 32'd0);
        chk("lw_x0_wb_data",  wb_data, 32'h1234_5678);

        // LHU 0x2
        dmem_rdata = 32'hF00D_0000;
        issue(5'd9, 32'h2, 1'b1, 1'b1, 1'b0, 2'd1, 1'b1, 32'd0);
        @(negedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        chk("lhu_wb_valid", 32'(wb_valid), 32'd1);
        chk("lhu_wb_data",  wb_data, 32'h0000_F00D);
        chk("lhu_wb_en",    32'(wb_en), 32'd1);

        // LH 0x0 sign-extends the low half
        dmem_rdata = 32'h0000_8001;
        issue(5'd10, 32'h0, 1'b1, 1'b1, 1'b0, 2'd1, 1'b0, 32'd0);
        @(negedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        dmem_resp_valid = 1'b0;
        chk("lh_wb_data", wb_data, 32'hFFFF_8001);

        // Reset while in RESP, then a stray response
        dmem_req_ready = 1'b1;
        issue(5'd4, 32'h40, 1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 32'd0);
        @(negedge clk);
        @(negedge clk);
        chk("rst_resp_stall", 32'(stall), 32'd1);
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("rst_mid");
        rst = 1'b0;
        dmem_resp_valid = 1'b1;
        @(negedge clk);
        dmem_resp_valid = 1'b0;
        chk("rst_stray_wbv",   32'(wb_valid), 32'd0);
        chk("rst_stray_stall", 32'(stall), 32'd0);
        chk("rst_stray_req",   32'(dmem_req_valid), 32'd0);
        issue(5'd6, 32'hBEEF, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        chk("rst_after_alu_wbv",  32'(wb_valid), 32'd1);
        chk("rst_after_alu_data", wb_data, 32'hBEEF);

        // Misaligned LW 0x101
        dmem_req_ready = 1'b1;
        dmem_resp_valid = 1'b1;
        dmem_rdata = 32'hCAFE_F00D;
        issue(5'd8, 32'h101, 1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 32'd0);
`ifdef MEM_MISALIGN_TRAP_EN
        #1 chk("mis_stall", 32'(stall), 32'd0);
        chk("mis_req_c0", 32'(dmem_req_valid), 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        chk("mis_trap",     32'(trap), 32'd1);
        chk("mis_wb_valid", 32'(wb_valid), 32'd1);
        chk("mis_wb_en",    32'(wb_en), 32'd0);
        chk("mis_req_c1",   32'(dmem_req_valid), 32'd0);
        @(negedge clk);
        chk("mis_trap_pulse", 32'(trap), 32'd0);
        chk("mis_req_c2",     32'(dmem_req_valid), 32'd0);
`else
        #1 chk("mis_stall", 32'(stall), 32'd1);
        @(negedge clk);
        chk("mis_addr", dmem_addr, 32'h100);
        chk("mis_trap", 32'(trap), 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        chk("mis_wb_data", wb_data, 32'hCAFE_F00D);
        chk("mis_wb_en",   32'(wb_en), 32'd1);
`endif
        dmem_resp_valid = 1'b0;
        dmem_req_ready = 1'b0;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
